// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned REQ_INSTR      = 0;
    localparam int unsigned REQ_DATA       = 1;
    localparam int unsigned NUM_REQ        = 2;

    // Request bundles are carried at the widest supported size and narrowed at the ports
    localparam int unsigned REQ_ADDR_MAX_W = 64;
    localparam int unsigned REQ_DATA_MAX_W = 64;
    localparam int unsigned REQ_BE_MAX_W   = REQ_DATA_MAX_W / 8;

    typedef logic req_id_t;

    typedef struct packed {
        logic [REQ_ADDR_MAX_W-1:0] addr;
        logic                      we;
        logic [REQ_BE_MAX_W-1:0]   be;
        logic [REQ_DATA_MAX_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (two requesters) and RAM-side req/gnt/rvalid signals of the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [1:0]              m_req;
    logic [1:0]              m_gnt;
    logic [1:0]              m_rvalid;
    logic [2*ADDR_WIDTH-1:0] m_addr;
    logic [1:0]              m_we;
    logic [2*BE_W-1:0]       m_be;
    logic [2*DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0]   m_rdata;

    logic                    mem_req;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic [BE_W-1:0]         mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // Arbiter view
    modport master (
        input  m_req, m_addr, m_we, m_be, m_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output m_gnt, m_rvalid, m_rdata,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

    // Core + RAM view
    modport slave (
        output m_req, m_addr, m_we, m_be, m_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  m_gnt, m_rvalid, m_rdata,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of owner tags, one entry per outstanding RAM access.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    req_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Tag storage needs no reset: count gates every read
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one sp_ram port between instruction fetch and LSU.
// Optional MEM_PORT_ARBITER_PERF_EN adds grant and conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.master bus,
    output logic               err_o
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]        perf_gnt_o [2],
    output logic [31:0]        perf_conflict_o
`endif
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    mem_req_t    req_c [NUM_REQ];
    mem_req_t    sel_c;
    req_id_t     rr_q;
    req_id_t     winner_c;
    req_id_t     head_tag;
    logic        any_req_c;
    logic        mem_req_c;
    logic        handshake_c;
    logic        pop_c;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  gnt_c;

    // Unpack the flat requester buses into per-requester bundles
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_c[k]       = '0;
            req_c[k].addr  = REQ_ADDR_MAX_W'(bus.m_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
            req_c[k].we    = bus.m_we[k];
            req_c[k].be    = REQ_BE_MAX_W'(bus.m_be[k*BE_W +: BE_W]);
            req_c[k].wdata = REQ_DATA_MAX_W'(bus.m_wdata[k*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Contention goes to whoever was not granted last; rr only moves on a handshake,
    // so a stalled winner keeps the port until it is granted
    always_comb begin
        winner_c = req_id_t'(REQ_INSTR);
        if (bus.m_req[REQ_INSTR] && bus.m_req[REQ_DATA]) begin
            winner_c = ~rr_q;
        end else if (bus.m_req[REQ_DATA]) begin
            winner_c = req_id_t'(REQ_DATA);
        end
    end

    always_comb begin
        sel_c = '0;
        if (any_req_c) begin
            sel_c = winner_c ? req_c[REQ_DATA] : req_c[REQ_INSTR];
        end
    end

    // Full is registered state only, keeping mem_rvalid out of the mem_req path
    assign any_req_c   = |bus.m_req;
    assign mem_req_c   = any_req_c & ~fifo_full & ~rst_i;
    assign handshake_c = mem_req_c & bus.mem_gnt;
    assign gnt_c       = handshake_c ? id_onehot(winner_c) : 2'b00;
    assign pop_c       = bus.mem_rvalid & ~fifo_empty;

    assign bus.mem_req   = mem_req_c;
    assign bus.mem_addr  = ADDR_WIDTH'(sel_c.addr);
    assign bus.mem_we    = sel_c.we;
    assign bus.mem_be    = BE_W'(sel_c.be);
    assign bus.mem_wdata = DATA_WIDTH'(sel_c.wdata);
    assign bus.m_gnt     = gnt_c;
    assign bus.m_rvalid  = pop_c ? id_onehot(head_tag) : 2'b00;
    assign bus.m_rdata   = bus.mem_rdata;

    mem_arb_tag_fifo #(
        .DEPTH     (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (handshake_c),
        .push_id_i (winner_c),
        .pop_i     (pop_c),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head_tag)
    );

    // Round-robin pointer and sticky orphan-response flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q  <= req_id_t'(REQ_INSTR);
            err_o <= 1'b0;
        end else begin
            if (handshake_c) begin
                rr_q <= winner_c;
            end
            if (bus.mem_rvalid && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_gnt_o[0]   <= '0;
            perf_gnt_o[1]   <= '0;
            perf_conflict_o <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt_c[k]) begin
                    perf_gnt_o[k] <= perf_gnt_o[k] + 32'd1;
                end
            end
            if (&bus.m_req) begin
                perf_conflict_o <= perf_conflict_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = DW / 8;
    localparam int unsigned MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] perf_gnt [2];
    logic [31:0] perf_conflict;
`endif

    mem_port_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bus),
        .err_o           (err)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .perf_gnt_o      (perf_gnt),
        .perf_conflict_o (perf_conflict)
`endif
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: owners of outstanding accesses in issue order
    int          q[$];
    int          rr_m;
    bit          err_m;
    int unsigned gcnt [2];
    int unsigned ccnt;

    int          e_w;
    bit          e_hs;
    bit          e_mem_req;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rvalid;
    logic [AW-1:0] e_addr;
    logic        e_we;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wdata;

    task automatic drive_idle();
        bus.m_req      = 2'b00;
        bus.m_addr     = '0;
        bus.m_we       = 2'b00;
        bus.m_be       = '0;
        bus.m_wdata    = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic model_reset();
        q.delete();
        rr_m    = 0;
        err_m   = 1'b0;
        gcnt[0] = 0;
        gcnt[1] = 0;
        ccnt    = 0;
        e_gnt   = 2'b00;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Expected outputs for the inputs currently applied
    task automatic calc_exp();
        int  n    = q.size();
        bit  full = (n >= int'(MAXO));
        bit  any  = (bus.m_req != 2'b00);
        if (bus.m_req == 2'b11) e_w = (rr_m == 0) ? 1 : 0;
        else                    e_w = bus.m_req[1] ? 1 : 0;
        e_mem_req = any && !full;
        e_hs      = e_mem_req && bus.mem_gnt;
        e_gnt     = e_hs ? 2'(1 << e_w) : 2'b00;
        e_rvalid  = (bus.mem_rvalid && n > 0) ? 2'(1 << q[0]) : 2'b00;
        e_addr    = any ? bus.m_addr[e_w*AW +: AW] : '0;
        e_we      = any ? bus.m_we[e_w] : 1'b0;
        e_be      = any ? bus.m_be[e_w*BW +: BW] : '0;
        e_wdata   = any ? bus.m_wdata[e_w*DW +: DW] : '0;
    endtask

    // Clock edge: retire responses, record grants
    task automatic advance();
        @(posedge clk);
        if (bus.mem_rvalid) begin
            if (q.size() > 0) void'(q.pop_front());
            else              err_m = 1'b1;
        end
        if (e_hs) begin
            q.push_back(e_w);
            rr_m = e_w;
            gcnt[e_w]++;
        end
        if (bus.m_req == 2'b11) ccnt++;
        #1;
    endtask

    task automatic test_reset();
        #1;
        rst            = 1'b1;
        bus.m_req      = 2'b11;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.m_gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", bus.m_gnt); end
        n_cmp++; if (bus.m_rvalid !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", bus.m_rvalid); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus.m_req   = 2'b01;
        bus.m_addr  = {32'h0000_0000, 32'h0000_0010};
        bus.mem_gnt = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.m_gnt !== 2'b01) begin n_bad++; $display("FAIL single_gnt: got %b want 01", bus.m_gnt); end
        n_cmp++; if (bus.mem_addr !== 32'h10) begin n_bad++; $display("FAIL single_addr: got %h want 10", bus.mem_addr); end
        advance();
        bus.m_req      = 2'b00;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        #1; calc_exp();
        n_cmp++; if (bus.m_rvalid !== 2'b01) begin n_bad++; $display("FAIL single_rvalid: got %b want 01", bus.m_rvalid); end
        n_cmp++; if (bus.m_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_rdata: got %h want deadbeef", bus.m_rdata); end
        advance();
        drive_idle();
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        do_reset();
        bus.m_req   = 2'b11;
        bus.m_addr  = {32'h0000_2000, 32'h0000_1000};
        bus.mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = (i > 0);
            #1; calc_exp();
            n_cmp++; if (bus.m_gnt !== exp_g[i]) begin n_bad++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, bus.m_gnt, exp_g[i]); end
            if (i > 0) begin
                n_cmp++; if (bus.m_rvalid !== exp_g[i-1]) begin n_bad++; $display("FAIL alt_rvalid[%0d]: got %b want %b", i, bus.m_rvalid, exp_g[i-1]); end
            end
            advance();
        end
        bus.m_req      = 2'b00;
        bus.mem_rvalid = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.m_rvalid !== exp_g[3]) begin n_bad++; $display("FAIL alt_rvalid_last: got %b want %b", bus.m_rvalid, exp_g[3]); end
        advance();
        drive_idle();
    endtask

    task automatic test_full();
        do_reset();
        bus.m_req   = 2'b01;
        bus.m_addr  = {32'h0, 32'h0000_0400};
        bus.mem_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1; calc_exp();
            n_cmp++; if (bus.m_gnt !== 2'b01) begin n_bad++; $display("FAIL full_fill_gnt[%0d]: got %b want 01", i, bus.m_gnt); end
            advance();
        end
        #1; calc_exp();
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL full_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.m_gnt !== 2'b00) begin n_bad++; $display("FAIL full_gnt: got %b want 00", bus.m_gnt); end
        advance();
        bus.mem_rvalid = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL full_pop_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.m_rvalid !== 2'b01) begin n_bad++; $display("FAIL full_pop_rvalid: got %b want 01", bus.m_rvalid); end
        advance();
        bus.mem_rvalid = 1'b0;
        #1; calc_exp();
        n_cmp++; if (bus.m_gnt !== 2'b01) begin n_bad++; $display("FAIL full_resume_gnt: got %b want 01", bus.m_gnt); end
        advance();
        drive_idle();
    endtask

    task automatic test_stall();
        do_reset();
        bus.m_addr  = {32'hA5A5_0040, 32'h0000_0080};
        bus.m_req   = 2'b10;
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; calc_exp();
            n_cmp++; if (bus.m_gnt !== 2'b00) begin n_bad++; $display("FAIL stall_gnt[%0d]: got %b want 00", i, bus.m_gnt); end
            n_cmp++; if (bus.mem_addr !== 32'hA5A5_0040) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want a5a50040", i, bus.mem_addr); end
            advance();
        end
        bus.mem_gnt = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.m_gnt !== 2'b10) begin n_bad++; $display("FAIL stall_release_gnt: got %b want 10", bus.m_gnt); end
        advance();
        // Data granted last: a stalled instr request must keep the port once data joins in
        bus.m_req      = 2'b01;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.m_rvalid !== 2'b10) begin n_bad++; $display("FAIL stall_rvalid: got %b want 10", bus.m_rvalid); end
        advance();
        bus.mem_rvalid = 1'b0;
        bus.m_req      = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1; calc_exp();
            n_cmp++; if (bus.mem_addr !== 32'h0000_0080) begin n_bad++; $display("FAIL hold_addr[%0d]: got %h want 00000080", i, bus.mem_addr); end
            advance();
        end
        bus.mem_gnt = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.m_gnt !== 2'b01) begin n_bad++; $display("FAIL hold_gnt: got %b want 01", bus.m_gnt); end
        advance();
        drive_idle();
    endtask

    task automatic test_err();
        do_reset();
        bus.mem_rvalid = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.m_rvalid !== 2'b00) begin n_bad++; $display("FAIL err_rvalid: got %b want 00", bus.m_rvalid); end
        advance();
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky[%0d]: got %b want 1", i, err); end
            advance();
        end
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.m_req   = 2'b01;
        bus.mem_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1; calc_exp(); advance();
        end
        rst            = 1'b1;
        bus.m_req      = 2'b11;
        bus.mem_rvalid = 1'b1;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL arst_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.m_gnt !== 2'b00) begin n_bad++; $display("FAIL arst_gnt: got %b want 00", bus.m_gnt); end
        n_cmp++; if (bus.m_rvalid !== 2'b00) begin n_bad++; $display("FAIL arst_rvalid: got %b want 00", bus.m_rvalid); end
`ifdef MEM_PORT_ARBITER_PERF_EN
        n_cmp++; if (perf_gnt[0] !== 32'd0) begin n_bad++; $display("FAIL arst_perf_gnt0: got %0d want 0", perf_gnt[0]); end
        n_cmp++; if (perf_conflict !== 32'd0) begin n_bad++; $display("FAIL arst_perf_conflict: got %0d want 0", perf_conflict); end
`endif
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b0;
        model_reset();
        bus.mem_rvalid = 1'b1;
        #1; calc_exp();
        n_cmp++; if (bus.m_rvalid !== 2'b00) begin n_bad++; $display("FAIL arst_stray_rvalid: got %b want 00", bus.m_rvalid); end
        advance();
        bus.mem_rvalid = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL arst_stray_err: got %b want 1", err); end
        advance();
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            // Pending, ungranted requests stay stable; others re-roll
            for (int k = 0; k < 2; k++) begin
                if (!(bus.m_req[k] && !e_gnt[k])) begin
                    bus.m_req[k]              = ($urandom_range(0, 3) != 0);
                    bus.m_addr[k*AW +: AW]    = $urandom;
                    bus.m_we[k]               = 1'($urandom_range(0, 1));
                    bus.m_be[k*BW +: BW]      = BW'($urandom);
                    bus.m_wdata[k*DW +: DW]   = $urandom;
                end
            end
            bus.mem_gnt    = ($urandom_range(0, 3) != 0);
            bus.mem_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.mem_rdata  = $urandom;
            #1; calc_exp();
            n_cmp++; if (bus.mem_req !== e_mem_req) begin n_bad++; $display("FAIL rnd_mem_req@%0d: got %b want %b", c, bus.mem_req, e_mem_req); end
            n_cmp++; if (bus.m_gnt !== e_gnt) begin n_bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, bus.m_gnt, e_gnt); end
            n_cmp++; if (bus.m_rvalid !== e_rvalid) begin n_bad++; $display("FAIL rnd_rvalid@%0d: got %b want %b", c, bus.m_rvalid, e_rvalid); end
            n_cmp++; if ({bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {e_addr, e_we, e_be, e_wdata})
                begin n_bad++; $display("FAIL rnd_payload@%0d: got %h/%b/%h/%h want %h/%b/%h/%h", c, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata, e_addr, e_we, e_be, e_wdata); end
            n_cmp++; if (err !== err_m) begin n_bad++; $display("FAIL rnd_err@%0d: got %b want %b", c, err, err_m); end
            if (e_rvalid != 2'b00) begin
                n_cmp++; if (bus.m_rdata !== bus.mem_rdata) begin n_bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", c, bus.m_rdata, bus.mem_rdata); end
            end
            advance();
        end
`ifdef MEM_PORT_ARBITER_PERF_EN
        n_cmp++; if (perf_gnt[0] !== 32'(gcnt[0])) begin n_bad++; $display("FAIL perf_gnt0: got %0d want %0d", perf_gnt[0], gcnt[0]); end
        n_cmp++; if (perf_gnt[1] !== 32'(gcnt[1])) begin n_bad++; $display("FAIL perf_gnt1: got %0d want %0d", perf_gnt[1], gcnt[1]); end
        n_cmp++; if (perf_conflict !== 32'(ccnt)) begin n_bad++; $display("FAIL perf_conflict: got %0d want %0d", perf_conflict, ccnt); end
`endif
        drive_idle();
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_stall();
        test_err();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "time limit");
    end

endmodule
